// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the 32-bit instruction fetch
//               unit: FSM state encoding, queue depth, reset PC and the
//               fetch-queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_32_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_32_if
// Description : Redirect, I-cache request/response and decode channels of
//               the fetch unit. master = fetch unit, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_32_if #(
  parameter int unsigned VIRTUAL_ADDR_LEN = 32
);

  logic                        redirect_valid_i;
  logic [VIRTUAL_ADDR_LEN-1:0] redirect_pc_i;

  logic                        req_valid_o;
  logic                        req_ready_i;
  logic [VIRTUAL_ADDR_LEN-1:0] req_addr_o;

  logic                        resp_valid_i;
  logic                        resp_ready_o;
  logic [31:0]                 resp_data_i;

  logic                        inst_valid_o;
  logic                        inst_ready_i;
  logic [31:0]                 inst_o;
  logic [VIRTUAL_ADDR_LEN-1:0] pc_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i,
    output req_valid_o, req_addr_o,
    input  req_ready_i,
    input  resp_valid_i, resp_data_i,
    output resp_ready_o,
    output inst_valid_o, inst_o, pc_o,
    input  inst_ready_i
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i,
    input  req_valid_o, req_addr_o,
    output req_ready_i,
    output resp_valid_i, resp_data_i,
    input  resp_ready_o,
    input  inst_valid_o, inst_o, pc_o,
    output inst_ready_i
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetched {inst, pc} entries. Head entry is
//               read straight from the storage registers, so a push at edge
//               N becomes visible after edge N. Flush overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = fetch_pkg::FQ_DEPTH
) (
  input  wire                          clk,
  input  wire                          rstn,
  input  wire                          flush_i,
  input  wire                          push_i,
  input  fq_entry_t                    push_data_i,
  input  wire                          pop_i,
  output fq_entry_t                    head_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fq_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit_32.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_32
// Description : Single-outstanding-request instruction fetch unit. Issues
//               sequential PCs to the L1 I-cache, queues responses for decode
//               and restarts at a redirect PC, dropping stale responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_32
  import fetch_pkg::*;
#(
  parameter int unsigned VIRTUAL_ADDR_LEN = 32,
  parameter logic [31:0] RESET_PC         = fetch_pkg::RESET_PC,
  parameter int unsigned FQ_DEPTH         = fetch_pkg::FQ_DEPTH
) (
  input  wire               clk,
  input  wire               rstn,
  fetch_unit_32_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned VA    = VIRTUAL_ADDR_LEN;

  fetch_state_e     state_q, state_d;
  logic [VA-1:0]    pc_q, pc_d;
  logic [VA-1:0]    issue_pc_q, issue_pc_d;

  logic [CNT_W-1:0] fq_count;
  fq_entry_t        fq_head;
  fq_entry_t        fq_push_data;
  logic             fq_push;
  logic             fq_pop;

  logic             redirect;
  logic [VA-1:0]    redirect_pc_aligned;
  logic             req_valid;
  logic             req_hs;
  logic             resp_ready;
  logic             unused_redirect_lsbs;

  assign redirect             = bus.redirect_valid_i;
  assign redirect_pc_aligned  = {bus.redirect_pc_i[VA-1:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc_i[1:0];

  // Request only with room left in the queue; held low while in reset.
  assign req_valid  = rstn && (state_q == S_REQ) && (fq_count < CNT_W'(FQ_DEPTH));
  assign req_hs     = req_valid && bus.req_ready_i;
  assign resp_ready = (state_q != S_REQ);

  // A redirect flushes the queue, so it suppresses both push and pop.
  assign fq_push      = (state_q == S_WAIT) && bus.resp_valid_i && !redirect;
  assign fq_pop       = (fq_count != '0) && bus.inst_ready_i && !redirect;
  assign fq_push_data = '{inst: bus.resp_data_i, pc: 32'(issue_pc_q)};

  assign bus.req_valid_o  = req_valid;
  assign bus.req_addr_o   = pc_q;
  assign bus.resp_ready_o = resp_ready;
  assign bus.inst_valid_o = (fq_count != '0);
  assign bus.inst_o       = fq_head.inst;
  assign bus.pc_o         = VA'(fq_head.pc);

  // State and PC registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_REQ;
      pc_q       <= VA'(RESET_PC);
      issue_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
    end
  end

  // Next state and PC: a handshake racing a redirect is stale and must be drained.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          state_d = redirect ? S_DROP : S_WAIT;
          if (!redirect) begin
            issue_pc_d = pc_q;
            pc_d       = pc_q + VA'(4);
          end
        end
      end
      S_WAIT: begin
        if (bus.resp_valid_i) begin
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.resp_valid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect) begin
      pc_d = redirect_pc_aligned;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (redirect),
    .push_i      (fq_push),
    .push_data_i (fq_push_data),
    .pop_i       (fq_pop),
    .head_o      (fq_head),
    .count_o     (fq_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit_32
// Description : Directed bench for fetch_unit_32 with an I-cache model that
//               answers two cycles after each request and a scoreboard of
//               expected {inst, pc} entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit_32;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fetch_unit_32_if #(.VIRTUAL_ADDR_LEN(32)) ifc ();

  fetch_unit_32 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  fq_entry_t   exp_q[$];
  logic [31:0] req_log[$];
  int          req_edge[$];
  logic [31:0] pop_log[$];
  int          edge_cnt      = 0;
  int          first_iv_edge = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_edge.delete();
    pop_log.delete();
    first_iv_edge = -1;
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // I-cache model: response valid in the second cycle after the handshake.
  initial begin
    logic        hs;
    logic        acc;
    logic        pend;
    logic [31:0] paddr;
    ifc.resp_valid_i = 1'b0;
    ifc.resp_data_i  = '0;
    pend  = 1'b0;
    paddr = '0;
    forever begin
      @(negedge clk);
      hs  = rstn && ifc.req_valid_o && ifc.req_ready_i;
      acc = ifc.resp_valid_i && ifc.resp_ready_o;
      if (hs) paddr = ifc.req_addr_o;
      @(posedge clk);
      #2;
      if (!rstn) begin
        pend             = 1'b0;
        ifc.resp_valid_i = 1'b0;
      end else begin
        if (acc) ifc.resp_valid_i = 1'b0;
        if (hs) begin
          pend = 1'b1;
        end else if (pend) begin
          ifc.resp_valid_i = 1'b1;
          ifc.resp_data_i  = mem_word(paddr);
          pend             = 1'b0;
        end
      end
    end
  end

  // Scoreboard: expectations queued at request time, checked at decode pop.
  initial forever begin
    fq_entry_t e;
    @(negedge clk);
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (ifc.inst_valid_o && first_iv_edge < 0) first_iv_edge = edge_cnt;
      if (ifc.inst_valid_o && ifc.inst_ready_i) begin
        pop_log.push_back(ifc.pc_o);
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("inst_o", ifc.inst_o, e.inst);
          check("pc_o", ifc.pc_o, e.pc);
        end
      end
      if (ifc.redirect_valid_i) begin
        exp_q.delete();
      end else if (ifc.req_valid_o && ifc.req_ready_i) begin
        exp_q.push_back('{inst: mem_word(ifc.req_addr_o), pc: ifc.req_addr_o});
      end
      if (ifc.req_valid_o && ifc.req_ready_i) begin
        req_log.push_back(ifc.req_addr_o);
        req_edge.push_back(edge_cnt + 1);
      end
    end
  end

  initial begin
    int tgt;
    logic [31:0] exp_addr;
    ifc.redirect_valid_i = 1'b0;
    ifc.redirect_pc_i    = '0;
    ifc.req_ready_i      = 1'b1;
    ifc.inst_ready_i     = 1'b1;

    // Reset values
    rstn = 1'b0;
    tick(3);
    check("rst_req_valid", 32'(ifc.req_valid_o), 32'd0);
    check("rst_resp_ready", 32'(ifc.resp_ready_o), 32'd0);
    check("rst_inst_valid", 32'(ifc.inst_valid_o), 32'd0);
    check("rst_inst_o", ifc.inst_o, 32'd0);
    check("rst_pc_o", ifc.pc_o, 32'd0);

    // First cycle after release, then sequential fetch with hit latency
    clear_logs();
    rstn = 1'b1;
    #1;
    check("post_rst_req_valid", 32'(ifc.req_valid_o), 32'd1);
    check("post_rst_req_addr", ifc.req_addr_o, RPC);
    check("post_rst_resp_ready", 32'(ifc.resp_ready_o), 32'd0);
    tick(12);
    check("seq_req0", req_log[0], 32'h8000_0000);
    check("seq_req1", req_log[1], 32'h8000_0004);
    check("seq_req2", req_log[2], 32'h8000_0008);
    check("seq_pop0", pop_log[0], 32'h8000_0000);
    check("latency", 32'(first_iv_edge - req_edge[0]), 32'd2);
    check("throughput", 32'(req_edge[1] - req_edge[0]), 32'd3);

    // Decode stalled: queue fills, fetch stops, then drains in order
    rstn = 1'b0;
    ifc.inst_ready_i = 1'b0;
    tick(2);
    clear_logs();
    rstn = 1'b1;
    tick(20);
    check("full_req_count", 32'(req_log.size()), 32'd4);
    check("full_req_valid", 32'(ifc.req_valid_o), 32'd0);
    check("full_inst_valid", 32'(ifc.inst_valid_o), 32'd1);
    ifc.inst_ready_i = 1'b1;
    tick(12);
    check("drain_pop0", pop_log[0], 32'h8000_0000);
    check("drain_pop3", pop_log[3], 32'h8000_000C);
    check("resume_req", req_log[4], 32'h8000_0010);

    // Redirect while waiting on the cache
    ifc.inst_ready_i = 1'b0;
    tgt = req_log.size() + 2;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (req_log.size() >= tgt) break;
    end
    #1;
    check("wait_hs_a", 32'(req_log.size() >= tgt), 32'd1);
    check("pre_redir_inst_valid", 32'(ifc.inst_valid_o), 32'd1);
    ifc.redirect_valid_i = 1'b1;
    ifc.redirect_pc_i    = 32'h0000_1003;
    tick(1);
    ifc.redirect_valid_i = 1'b0;
    check("redir_flush", 32'(ifc.inst_valid_o), 32'd0);
    check("redir_drop_req_valid", 32'(ifc.req_valid_o), 32'd0);
    check("redir_drop_resp_ready", 32'(ifc.resp_ready_o), 32'd1);
    clear_logs();
    ifc.inst_ready_i = 1'b1;
    tick(10);
    check("redir_req", req_log[0], 32'h0000_1000);
    check("redir_pop", pop_log[0], 32'h0000_1000);

    // Redirect on the same edge as the first request handshake
    rstn = 1'b0;
    tick(2);
    clear_logs();
    rstn = 1'b1;
    ifc.redirect_valid_i = 1'b1;
    ifc.redirect_pc_i    = 32'h0000_2000;
    tick(1);
    ifc.redirect_valid_i = 1'b0;
    check("hs_redir_req_valid", 32'(ifc.req_valid_o), 32'd0);
    check("hs_redir_resp_ready", 32'(ifc.resp_ready_o), 32'd1);
    tick(12);
    check("hs_redir_stale_req", req_log[0], 32'h8000_0000);
    check("hs_redir_next_req", req_log[1], 32'h0000_2000);
    check("hs_redir_pop", pop_log[0], 32'h0000_2000);

    // Stalled request holds its address; redirect to the top of memory wraps
    ifc.req_ready_i = 1'b0;
    tick(6);
    exp_addr = req_log[req_log.size() - 1] + 32'd4;
    check("stall_req_valid", 32'(ifc.req_valid_o), 32'd1);
    check("stall_addr_a", ifc.req_addr_o, exp_addr);
    tick(2);
    check("stall_addr_b", ifc.req_addr_o, exp_addr);
    ifc.redirect_valid_i = 1'b1;
    ifc.redirect_pc_i    = 32'hFFFF_FFFF;
    tick(1);
    ifc.redirect_valid_i = 1'b0;
    check("wrap_addr_now", ifc.req_addr_o, 32'hFFFF_FFFC);
    clear_logs();
    ifc.req_ready_i = 1'b1;
    tick(8);
    check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
    check("wrap_req1", req_log[1], 32'h0000_0000);

    // Reset in the middle of a request with two queued entries
    ifc.inst_ready_i = 1'b0;
    tgt = req_log.size() + 3;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (req_log.size() >= tgt) break;
    end
    #1;
    check("wait_hs_b", 32'(req_log.size() >= tgt), 32'd1);
    check("pre_rst_inst_valid", 32'(ifc.inst_valid_o), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(ifc.req_valid_o), 32'd0);
    check("mid_rst_resp_ready", 32'(ifc.resp_ready_o), 32'd0);
    check("mid_rst_inst_valid", 32'(ifc.inst_valid_o), 32'd0);
    check("mid_rst_inst_o", ifc.inst_o, 32'd0);
    check("mid_rst_pc_o", ifc.pc_o, 32'd0);
    tick(2);
    clear_logs();
    rstn = 1'b1;
    #1;
    check("rerst_req_valid", 32'(ifc.req_valid_o), 32'd1);
    check("rerst_req_addr", ifc.req_addr_o, RPC);
    check("rerst_resp_ready", 32'(ifc.resp_ready_o), 32'd0);
    check("rerst_inst_valid", 32'(ifc.inst_valid_o), 32'd0);
    ifc.inst_ready_i = 1'b1;
    tick(10);
    check("rerst_req0", req_log[0], RPC);
    check("rerst_pop0", pop_log[0], RPC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit_32.md
FETCH_UNIT_32 -- requirements
Module: fetch_unit_32

Interface
REQ-001 SHALL have parameter VIRTUAL_ADDR_LEN, default 32, meaning fetch address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter FQ_DEPTH, default 4, meaning fetch-queue entries (power of two, at least 2).
REQ-004 SHALL have one clock and one reset; the reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 redirect_valid_i  in  1  flush and restart fetch at redirect_pc_i.
REQ-008 redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
REQ-009 req_valid_o / req_ready_i / req_addr_o  out/in/out  1/1/32  request channel to the L1 I-cache.
REQ-010 resp_valid_i / resp_ready_o / resp_data_i  in/out/in  1/1/32  response channel from the L1 I-cache.
REQ-011 inst_valid_o / inst_ready_i / inst_o / pc_o  out/in/out/out  1/1/32/32  instruction channel to decode.

Function
REQ-012 SHALL keep at most one I-cache request outstanding.
REQ-013 SHALL implement a 3-state FSM: S_REQ, S_WAIT, S_DROP.
REQ-014 S_REQ: req_valid_o=1 iff queue count < FQ_DEPTH; req_addr_o=pc.
- On req handshake without redirect: save pc as issue_pc, pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), go to S_WAIT.
REQ-015 S_WAIT: resp_ready_o=1; on resp_valid_i, push {resp_data_i, issue_pc} into the queue and go to S_REQ.
REQ-016 S_DROP: resp_ready_o=1; on resp_valid_i, discard the response and go to S_REQ.
REQ-017 resp_ready_o SHALL be 0 in S_REQ; req_valid_o SHALL be 0 in S_WAIT and S_DROP.
REQ-018 Redirect handling, same cycle as redirect_valid_i:
- Flush the queue (count<=0).
- Set pc<=redirect_pc_i with [1:0] forced to 00.
- Next state:
  - S_WAIT with no response that cycle -> S_DROP.
  - S_WAIT with a response that cycle -> response discarded, S_REQ.
  - S_DROP -> stays S_DROP unless a response arrives that cycle.
  - S_REQ with req handshake that cycle -> S_DROP (the issued request is stale).
  - S_REQ without handshake -> stays S_REQ.
REQ-019 Redirect SHALL take priority over queue push and pop in the same cycle; a pop handshake in that cycle is still considered consumed by decode.
REQ-020 req_addr_o may change while req_valid_o=1 and unaccepted only due to redirect; otherwise it is held stable.
REQ-021 Queue SHALL be FIFO-ordered with registered outputs: inst_valid_o=(count!=0), inst_o/pc_o from the head entry.
- An entry pushed at edge N is visible at N+1; no combinational bypass from resp to inst.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; pop when empty and push when full SHALL never occur (guaranteed by REQ-014).
REQ-023 Minimum latency SHALL be: req handshake at cycle N, response at N+2 (cache hit), inst_valid_o at N+3.
REQ-024 Sustained throughput SHALL be one instruction per (cache latency + 1) cycles; no prefetch beyond one request.

Reset
REQ-025 While rstn=0: req_valid_o=0, resp_ready_o=0, inst_valid_o=0, inst_o=0, pc_o=0, state=S_REQ, pc=RESET_PC, count=0, head/tail pointers=0.
REQ-026 Reset asserted mid-request SHALL abandon the request; a response arriving after reset release while in S_REQ is not accepted (resp_ready_o=0).
REQ-027 The first cycle after rstn rises SHALL present req_valid_o=1, req_addr_o=RESET_PC.

Structure
REQ-028 Shared package fetch_pkg SHALL hold the FSM state enum, FQ_DEPTH, RESET_PC and the queue-entry struct {inst[31:0], pc[31:0]}.
REQ-029 The queue SHALL be one sub-module, fetch_queue: sync FIFO with push, pop, flush and count, same clk/rstn.
REQ-030 The top level SHALL hold only the FSM, pc/issue_pc registers and handshake logic.

Verification
REQ-031 Reset release with cache hit in 2 cycles and inst_ready_i=1 -> req_addr_o sequence 8000_0000, 8000_0004, 8000_0008; pc_o matches each address; inst_o equals resp_data_i.
REQ-032 inst_ready_i=0 for 20 cycles -> exactly 4 requests issued, then req_valid_o=0; after releasing inst_ready_i, 4 pops in order and fetch resumes at 8000_0010.
REQ-033 Redirect to 32'h0000_1003 while in S_WAIT -> queue empties next cycle; stale response discarded; next req_addr_o=0000_1000; next inst has pc_o=0000_1000.
REQ-034 Redirect coinciding with req handshake at 8000_0000 -> S_DROP; its response is never output; next request goes to the redirect PC.
REQ-035 Redirect to FFFF_FFFC -> requests FFFF_FFFC then 0000_0000.
REQ-036 rstn pulsed low in S_WAIT with a queue of 2 entries -> all outputs 0 during reset; first post-reset request at RESET_PC; no old entries emitted.
